// File: rtl/irq_rst_ctl.sv
// Interrupt/reset front end for the 65C02 microcode sequencer: pin synchronizers, NMI edge latch,
// reset stretcher, vector select and WAI/STP halt. Build with WAI_STP_EN to get the WAIT/STOP states.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RST  | reset asserted to sequencer, stretch counter running
// ST_RUN  | normal execution, interrupts acknowledged at sync
// ST_WAIT | WAI executed, core halted until IRQ or NMI (WAI_STP_EN only)
// ST_STOP | STP executed, core halted until reset_n (WAI_STP_EN only)
module irq_rst_ctl #(
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       IRQ_n,
    input  logic       NMI_n,
    input  logic       sync,
    input  logic       I,
    input  logic       wai,
    input  logic       stp,
    output logic       reset,
    output logic       irq,
    output logic       I_eff,
    output logic [1:0] vec,
    output logic       halt,
    output logic       nmi_pending
);

`ifdef WAI_STP_EN
    typedef enum logic [1:0] {ST_RST, ST_RUN, ST_WAIT, ST_STOP} state_t;
`else
    typedef enum logic [1:0] {ST_RST, ST_RUN} state_t;
`endif

    localparam logic [3:0] CNT_LAST = 4'(RESET_CYCLES - 1);

    state_t                 state;
    logic [3:0]             cnt;
    logic [1:0]             rst_sync;
    logic [SYNC_STAGES-1:0] irq_sync;
    logic [SYNC_STAGES-1:0] nmi_sync;
    logic                   nmi_prev;
    logic                   rst_ok;
    logic                   irq_s;
    logic                   nmi_edge;
    logic                   take;
    logic                   ack;

    // Deassertion of reset_n is synchronized before the stretch counter may run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_sync <= '1;
            nmi_sync <= '1;
            nmi_prev <= 1'b1;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], IRQ_n};
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], NMI_n};
            nmi_prev <= nmi_sync[SYNC_STAGES-1];
        end
    end

    assign rst_ok   = rst_sync[1];
    assign irq_s    = ~irq_sync[SYNC_STAGES-1];
    assign nmi_edge = nmi_prev & ~nmi_sync[SYNC_STAGES-1];

    assign irq   = nmi_pending | irq_s;
    assign I_eff = I & ~nmi_pending;
    assign take  = nmi_pending | (irq_s & ~I);
    assign ack   = (state == ST_RUN) & sync & take;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RST;
            cnt         <= 4'd0;
            reset       <= 1'b1;
            vec         <= 2'b00;
            nmi_pending <= 1'b0;
`ifdef WAI_STP_EN
            halt        <= 1'b0;
`endif
        end else begin
            // A new edge in the acknowledge cycle must not be lost.
            if (nmi_edge) begin
                nmi_pending <= 1'b1;
            end else if (ack && nmi_pending) begin
                nmi_pending <= 1'b0;
            end

            if (ack) begin
                vec <= nmi_pending ? 2'b01 : 2'b10;
            end

            case (state)
                ST_RST: begin
                    if (rst_ok) begin
                        if (cnt == CNT_LAST) begin
                            state <= ST_RUN;
                            reset <= 1'b0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_RUN: begin
`ifdef WAI_STP_EN
                    if (sync && !ack) begin
                        if (stp) begin
                            state <= ST_STOP;
                            halt  <= 1'b1;
                        end else if (wai) begin
                            state <= ST_WAIT;
                            halt  <= 1'b1;
                        end
                    end
`endif
                end
`ifdef WAI_STP_EN
                ST_WAIT: begin
                    if (irq_s || nmi_pending) begin
                        state <= ST_RUN;
                        halt  <= 1'b0;
                    end
                end
                ST_STOP: begin
                    state <= ST_STOP;
                end
`endif
                default: begin
                    state <= ST_RST;
                end
            endcase
        end
    end

`ifndef WAI_STP_EN
    logic unused_inputs;
    assign unused_inputs = &{1'b0, wai, stp};
    assign halt          = 1'b0;
`endif

endmodule

// File: tb/tb_irq_rst_ctl.sv
// Self-checking bench for irq_rst_ctl: reset stretch, NMI edge latch, IRQ masking, priority,
// collision and (with WAI_STP_EN) the WAIT/STOP halt states.
module tb_irq_rst_ctl;

    localparam int SYNC_STAGES  = 2;
    localparam int RESET_CYCLES = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       IRQ_n   = 1'b1;
    logic       NMI_n   = 1'b1;
    logic       sync    = 1'b0;
    logic       I       = 1'b1;
    logic       wai     = 1'b0;
    logic       stp     = 1'b0;
    logic       reset;
    logic       irq;
    logic       I_eff;
    logic [1:0] vec;
    logic       halt;
    logic       nmi_pending;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] vec_q[$];
    logic [1:0] exp_vec;

    irq_rst_ctl #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .IRQ_n      (IRQ_n),
        .NMI_n      (NMI_n),
        .sync       (sync),
        .I          (I),
        .wai        (wai),
        .stp        (stp),
        .reset      (reset),
        .irq        (irq),
        .I_eff      (I_eff),
        .vec        (vec),
        .halt       (halt),
        .nmi_pending(nmi_pending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        int n;
        #2 reset_n = 1'b0;
        tick(3);
        n_tests++;
        if (reset !== 1'b1) begin n_fail++; $display("FAIL rst_reset got=%b exp=1", reset); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", irq); end
        n_tests++;
        if (vec !== 2'b00) begin n_fail++; $display("FAIL rst_vec got=%b exp=00", vec); end
        n_tests++;
        if (halt !== 1'b0) begin n_fail++; $display("FAIL rst_halt got=%b exp=0", halt); end
        n_tests++;
        if (nmi_pending !== 1'b0) begin n_fail++; $display("FAIL rst_nmi_pending got=%b exp=0", nmi_pending); end
        reset_n = 1'b1;
        n = 0;
        while (reset === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_tests++;
        if (n !== 2 + RESET_CYCLES) begin
            n_fail++; $display("FAIL rst_stretch cycles got=%0d exp=%0d", n, 2 + RESET_CYCLES);
        end
        n_tests++;
        if (vec !== 2'b00 || irq !== 1'b0) begin
            n_fail++; $display("FAIL rst_after vec=%b irq=%b exp vec=00 irq=0", vec, irq);
        end
    endtask

    task automatic test_nmi_edge;
        int n;
        logic bad;
        I     = 1'b1;
        NMI_n = 1'b0;
        n = 0;
        while (nmi_pending !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (n !== SYNC_STAGES + 1) begin
            n_fail++; $display("FAIL nmi_latency got=%0d exp=%0d", n, SYNC_STAGES + 1);
        end
        n_tests++;
        if (irq !== 1'b1 || I_eff !== 1'b0) begin
            n_fail++; $display("FAIL nmi_irq_ieff irq=%b I_eff=%b exp irq=1 I_eff=0", irq, I_eff);
        end
        sync = 1'b1;
        vec_q.push_back(2'b01);
        tick();
        sync = 1'b0;
        exp_vec = vec_q.pop_front();
        n_tests++;
        if (vec !== exp_vec) begin n_fail++; $display("FAIL nmi_ack_vec got=%b exp=%b", vec, exp_vec); end
        n_tests++;
        if (nmi_pending !== 1'b0) begin n_fail++; $display("FAIL nmi_ack_clear got=%b exp=0", nmi_pending); end
        bad = 1'b0;
        for (int k = 0; k < 16; k++) begin
            sync = k[0];
            tick();
            if (nmi_pending !== 1'b0 || irq !== 1'b0) bad = 1'b1;
        end
        sync = 1'b0;
        n_tests++;
        if (bad !== 1'b0) begin n_fail++; $display("FAIL nmi_held_low_retrigger got=1 exp=0"); end
        NMI_n = 1'b1;
        tick(4);
    endtask

    task automatic test_irq_mask;
        IRQ_n = 1'b0;
        I     = 1'b1;
        tick(SYNC_STAGES);
        n_tests++;
        if (irq !== 1'b1 || I_eff !== 1'b1) begin
            n_fail++; $display("FAIL irq_masked_level irq=%b I_eff=%b exp 1 1", irq, I_eff);
        end
        repeat (3) begin
            sync = 1'b1;
            tick();
            sync = 1'b0;
            tick();
        end
        n_tests++;
        if (vec !== 2'b01) begin n_fail++; $display("FAIL irq_masked_no_ack vec got=%b exp=01", vec); end
        I    = 1'b0;
        sync = 1'b1;
        vec_q.push_back(2'b10);
        tick();
        sync = 1'b0;
        exp_vec = vec_q.pop_front();
        n_tests++;
        if (vec !== exp_vec) begin n_fail++; $display("FAIL irq_unmasked_ack vec got=%b exp=%b", vec, exp_vec); end
        IRQ_n = 1'b1;
        tick(SYNC_STAGES);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_release got=%b exp=0", irq); end
    endtask

    task automatic test_priority;
        int n;
        I     = 1'b0;
        IRQ_n = 1'b0;
        NMI_n = 1'b0;
        n = 0;
        while (nmi_pending !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        sync = 1'b1;
        vec_q.push_back(2'b01);
        tick();
        sync = 1'b0;
        exp_vec = vec_q.pop_front();
        n_tests++;
        if (vec !== exp_vec) begin n_fail++; $display("FAIL prio_nmi_first vec got=%b exp=%b", vec, exp_vec); end
        n_tests++;
        if (irq !== 1'b1 || nmi_pending !== 1'b0) begin
            n_fail++; $display("FAIL prio_irq_remains irq=%b nmi_pending=%b exp 1 0", irq, nmi_pending);
        end
        sync = 1'b1;
        vec_q.push_back(2'b10);
        tick();
        sync = 1'b0;
        exp_vec = vec_q.pop_front();
        n_tests++;
        if (vec !== exp_vec) begin n_fail++; $display("FAIL prio_irq_second vec got=%b exp=%b", vec, exp_vec); end
        IRQ_n = 1'b1;
        NMI_n = 1'b1;
        tick(4);
    endtask

    task automatic test_collision;
        int n;
        I     = 1'b1;
        NMI_n = 1'b0;
        n = 0;
        while (nmi_pending !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        NMI_n = 1'b1;
        tick(SYNC_STAGES + 2);
        n_tests++;
        if (nmi_pending !== 1'b1) begin n_fail++; $display("FAIL coll_pending_held got=%b exp=1", nmi_pending); end
        NMI_n = 1'b0;
        tick(SYNC_STAGES);
        sync = 1'b1;
        vec_q.push_back(2'b01);
        tick();
        sync = 1'b0;
        exp_vec = vec_q.pop_front();
        n_tests++;
        if (vec !== exp_vec) begin n_fail++; $display("FAIL coll_vec got=%b exp=%b", vec, exp_vec); end
        n_tests++;
        if (nmi_pending !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins got=%b exp=1", nmi_pending); end
        sync = 1'b1;
        vec_q.push_back(2'b01);
        tick();
        sync = 1'b0;
        exp_vec = vec_q.pop_front();
        n_tests++;
        if (vec !== exp_vec || nmi_pending !== 1'b0) begin
            n_fail++; $display("FAIL coll_second_ack vec=%b nmi_pending=%b exp %b 0", vec, nmi_pending, exp_vec);
        end
        NMI_n = 1'b1;
        tick(4);
        // Level IRQ that goes away before it is acknowledged leaves no trace.
        I     = 1'b1;
        IRQ_n = 1'b0;
        tick(4);
        IRQ_n = 1'b1;
        tick(SYNC_STAGES + 1);
        I    = 1'b0;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        n_tests++;
        if (vec !== 2'b01 || irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_no_latch vec=%b irq=%b exp 01 0", vec, irq);
        end
    endtask

    task automatic test_mid_reset;
        int n;
        NMI_n = 1'b0;
        tick(SYNC_STAGES + 1);
        n_tests++;
        if (nmi_pending !== 1'b1) begin n_fail++; $display("FAIL mid_pending_set got=%b exp=1", nmi_pending); end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (reset !== 1'b1 || nmi_pending !== 1'b0 || vec !== 2'b00 || halt !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset reset=%b nmi_pending=%b vec=%b halt=%b exp 1 0 00 0", reset, nmi_pending, vec, halt);
        end
        NMI_n = 1'b1;
        tick(2);
        reset_n = 1'b1;
        n = 0;
        while (reset === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_tests++;
        if (n !== 2 + RESET_CYCLES) begin
            n_fail++; $display("FAIL mid_restretch cycles got=%0d exp=%0d", n, 2 + RESET_CYCLES);
        end
    endtask

`ifdef WAI_STP_EN
    task automatic test_wai;
        int n;
        I     = 1'b1;
        IRQ_n = 1'b1;
        NMI_n = 1'b1;
        sync  = 1'b1;
        wai   = 1'b1;
        tick();
        sync = 1'b0;
        wai  = 1'b0;
        n_tests++;
        if (halt !== 1'b1) begin n_fail++; $display("FAIL wai_halt got=%b exp=1", halt); end
        tick(3);
        n_tests++;
        if (halt !== 1'b1) begin n_fail++; $display("FAIL wai_halt_hold got=%b exp=1", halt); end
        IRQ_n = 1'b0;
        n = 0;
        while (halt === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (n !== SYNC_STAGES + 1) begin n_fail++; $display("FAIL wai_wake_latency got=%0d exp=%0d", n, SYNC_STAGES + 1); end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        n_tests++;
        if (vec !== 2'b00) begin n_fail++; $display("FAIL wai_masked_no_vec got=%b exp=00", vec); end
        // Pending interrupt at the WAI sync: the interrupt is taken and WAI is dropped.
        I = 1'b0;
        sync = 1'b1;
        wai  = 1'b1;
        vec_q.push_back(2'b10);
        tick();
        sync = 1'b0;
        wai  = 1'b0;
        exp_vec = vec_q.pop_front();
        n_tests++;
        if (vec !== exp_vec || halt !== 1'b0) begin
            n_fail++; $display("FAIL wai_ack_priority vec=%b halt=%b exp %b 0", vec, halt, exp_vec);
        end
        IRQ_n = 1'b1;
        tick(3);
    endtask

    task automatic test_stp;
        int n;
        I     = 1'b0;
        IRQ_n = 1'b1;
        sync  = 1'b1;
        stp   = 1'b1;
        wai   = 1'b1;
        tick();
        sync = 1'b0;
        stp  = 1'b0;
        wai  = 1'b0;
        n_tests++;
        if (halt !== 1'b1) begin n_fail++; $display("FAIL stp_halt got=%b exp=1", halt); end
        IRQ_n = 1'b0;
        tick(6);
        n_tests++;
        if (halt !== 1'b1) begin n_fail++; $display("FAIL stp_ignores_irq halt got=%b exp=1", halt); end
        NMI_n = 1'b0;
        tick(SYNC_STAGES + 1);
        n_tests++;
        if (nmi_pending !== 1'b1 || halt !== 1'b1) begin
            n_fail++; $display("FAIL stp_nmi_latched nmi_pending=%b halt=%b exp 1 1", nmi_pending, halt);
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        n_tests++;
        if (vec !== 2'b10 || nmi_pending !== 1'b1) begin
            n_fail++; $display("FAIL stp_no_ack vec=%b nmi_pending=%b exp 10 1", vec, nmi_pending);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (halt !== 1'b0 || nmi_pending !== 1'b0 || reset !== 1'b1 || vec !== 2'b00) begin
            n_fail++;
            $display("FAIL stp_reset halt=%b nmi_pending=%b reset=%b vec=%b exp 0 0 1 00", halt, nmi_pending, reset, vec);
        end
        tick(2);
        NMI_n = 1'b1;
        IRQ_n = 1'b1;
        reset_n = 1'b1;
        n = 0;
        while (reset === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        IRQ_n = 1'b0;
        tick(SYNC_STAGES);
        sync = 1'b1;
        vec_q.push_back(2'b10);
        tick();
        sync = 1'b0;
        exp_vec = vec_q.pop_front();
        n_tests++;
        if (vec !== exp_vec || halt !== 1'b0) begin
            n_fail++; $display("FAIL stp_resume vec=%b halt=%b exp %b 0", vec, halt, exp_vec);
        end
        IRQ_n = 1'b1;
        tick(3);
    endtask
`else
    task automatic test_wai_stp_disabled;
        I     = 1'b1;
        IRQ_n = 1'b1;
        sync  = 1'b1;
        wai   = 1'b1;
        tick();
        wai = 1'b0;
        stp = 1'b1;
        tick();
        sync = 1'b0;
        stp  = 1'b0;
        n_tests++;
        if (halt !== 1'b0) begin n_fail++; $display("FAIL nofeat_halt got=%b exp=0", halt); end
        I     = 1'b0;
        IRQ_n = 1'b0;
        tick(SYNC_STAGES);
        sync = 1'b1;
        vec_q.push_back(2'b10);
        tick();
        sync = 1'b0;
        exp_vec = vec_q.pop_front();
        n_tests++;
        if (vec !== exp_vec || halt !== 1'b0) begin
            n_fail++; $display("FAIL nofeat_runs vec=%b halt=%b exp %b 0", vec, halt, exp_vec);
        end
        IRQ_n = 1'b1;
        tick(3);
    endtask
`endif

    initial begin
        test_reset();
        test_nmi_edge();
        test_irq_mask();
        test_priority();
        test_collision();
        test_mid_reset();
`ifdef WAI_STP_EN
        test_wai();
        test_stp();
`else
        test_wai_stp_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irq_rst_ctl.md
Name: irq_rst_ctl

Overview:
- Interrupt and reset front end for the 65C02 microcode sequencer.
- Synchronizes the external IRQ_n/NMI_n pins and edge-detects NMI.
- Stretches the asynchronous reset into a clean synchronous sequencer reset.
- Resolves interrupt priority and selects the vector; implements the WAI/STP halt states.
- Feeds the sequencer's reset, irq and I inputs; gives the address stage the vector select and a halt (RDY) qualifier.

Parameters:
SYNC_STAGES, 2, flip-flop stages on IRQ_n/NMI_n synchronizers (min 2)
RESET_CYCLES, 4, cycles `reset` stays high after reset_n deasserts (1..15)

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
IRQ_n  input  1  external level interrupt request, async, active low
NMI_n  input  1  external non-maskable interrupt, async, falling-edge
sync  input  1  sequencer is decoding a new opcode this cycle
I  input  1  interrupt-disable flag from status register
wai  input  1  WAI opcode decoded, valid with sync
stp  input  1  STP opcode decoded, valid with sync
reset  output  1  synchronous active-high reset to sequencer
irq  output  1  interrupt request to sequencer
I_eff  output  1  I passed to sequencer = I & ~nmi_pending
vec  output  2  vector select: 00 RESET $FFFC, 01 NMI $FFFA, 10 IRQ/BRK $FFFE
halt  output  1  1 = hold core (RDY low); sequencer and address stage must not advance
nmi_pending  output  1  latched NMI awaiting service

Behaviour:
- Async reset (reset_n=0), immediate effect:
  - reset=1, irq=0, vec=00, halt=0, nmi_pending=0.
  - Synchronizer chains preset to 1 (inactive); state=RST; counter=0.
- State RST:
  - Counter increments each clk after reset_n is sampled high (reset_n passes its own 2-flop deassert synchronizer first).
  - When counter reaches RESET_CYCLES-1: reset drops next edge; state→RUN; vec stays 00 until the first ack.
- Synchronizers: IRQ_n and NMI_n pass SYNC_STAGES flops; irq_s = ~IRQ_n synced.
- NMI edge detection:
  - nmi_edge = synced NMI_n 1→0 transition between consecutive cycles.
  - nmi_edge sets nmi_pending. A held-low NMI_n gives exactly one edge.
  - Input-to-nmi_pending latency: SYNC_STAGES+1 cycles.
- irq output:
  - irq = nmi_pending | irq_s.
  - Combined with I_eff, the sequencer's internal irq&~I gating masks IRQ but never NMI.
- Ack (state RUN): ack = sync & irq & I_eff-qualified take, i.e. sync & (nmi_pending | (irq_s & ~I)).
  - On ack, vec registers 01 if nmi_pending, else 10. NMI beats IRQ.
  - NMI ack clears nmi_pending next edge. If nmi_edge occurs in the same cycle, nmi_pending stays 1 (set wins).
  - IRQ is level: no latch; deassert before ack = no interrupt.
  - vec holds until the next ack or reset. BRK uses the default 10 (sequencer-driven).
- State RUN→WAIT: sync & wai & no ack in the same cycle; halt=1 from next cycle.
- State WAIT:
  - halt=1.
  - Exit to RUN when irq_s | nmi_pending, regardless of I; halt=0 next cycle.
  - If I=1 and only IRQ: resume at the next instruction without a vector (sequencer sees masked irq).
- State RUN→STOP: sync & stp; halt=1 until reset_n asserted. Interrupts ignored; NMI edges still latched.
- Reset mid-operation (any state): immediate return to RST; nmi_pending cleared; vec=00.
- wai and stp both high: stp wins.
- ack has priority over wai/stp in the same sync cycle; the opcode is not executed.
- All outputs registered except irq and I_eff (combinational from registers and I).

Optional Feature:
WAI_STP_EN
- Defined: WAIT/STOP states and the halt output are implemented as above.
- Undefined: wai/stp inputs ignored (opcodes execute as NOPs), halt tied 0, state machine is RST/RUN only.

Test Plan:
- Reset: reset_n low 3 cycles then high, RESET_CYCLES=4 → reset high through 2 sync + 4 cycles, then 0; vec=00; irq=0.
- NMI edge: NMI_n 1→0 held low 20 cycles → nmi_pending=1 after 3 cycles; single ack with sync=1 → vec=01, nmi_pending=0, no second request while NMI_n stays low.
- IRQ masking: IRQ_n=0, I=1, sync pulses → irq=1 but no ack, vec unchanged. I→0 → next sync acks, vec=10.
- Priority and collision:
  - IRQ_n=0 and NMI edge pending at the same sync → vec=01, irq stays 1 afterward (IRQ still asserted).
  - Second NMI edge in the ack cycle → nmi_pending remains 1.
- WAI (WAI_STP_EN): sync&wai → halt=1 next cycle. IRQ_n=0 with I=1 → halt=0 after SYNC_STAGES+1 cycles, no ack, vec unchanged.
- STP (WAI_STP_EN): sync&stp → halt=1. NMI edge → halt stays 1. reset_n pulse → state RST, halt=0, nmi_pending=0.
